// File: rtl/mux_scan_capture.sv
// Sequential reader for a 7-to-1 mux: walks the select through each channel,
// samples the mux output and presents one 7-bit word with a valid/ack handshake.
// Optional macro MUX_SCAN_PARITY_EN adds an eighth slot (s=7) carrying even parity.
module mux_scan_capture #(
  parameter int SLOT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       din,
  input  logic       ack,
  output logic [2:0] s,
  output logic [6:0] q,
  output logic       valid,
  output logic       busy,
  output logic       par_err
);

  localparam int             CW       = $clog2(SLOT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
`ifdef MUX_SCAN_PARITY_EN
  localparam logic [2:0]     S_LAST   = 3'd7;
`else
  localparam logic [2:0]     S_LAST   = 3'd6;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    shadow_q, shadow_d;
  logic [6:0]    q_q, q_d;
  logic          valid_q, valid_d;
`ifdef MUX_SCAN_PARITY_EN
  logic          perr_q, perr_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= 3'd0;
      cnt_q    <= '0;
      shadow_q <= 7'd0;
      q_q      <= 7'd0;
      valid_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
`ifdef MUX_SCAN_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    valid_d  = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    perr_d   = perr_q;
`endif
    case (state_q)
      IDLE: begin
        s_d = 3'd0;
        if (start) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // The parity slot (s=7) has no shadow bit; channels 0..6 do.
          if (s_q != 3'd7) shadow_d[s_q] = din;
          if (s_q == S_LAST) begin
            state_d = DONE;
            s_d     = 3'd0;
            valid_d = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            q_d     = shadow_q;
            perr_d  = (^shadow_q) ^ din;
`else
            q_d     = {din, shadow_q[5:0]};
`endif
          end else begin
            s_d = s_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s     = s_q;
  assign q     = q_q;
  assign valid = valid_q;
  assign busy  = (state_q == SCAN);
`ifdef MUX_SCAN_PARITY_EN
  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture: two instances (1- and 3-cycle dwell)
// each fed by a bench-side mux model driven from the DUT select.
module tb_mux_scan_capture;

`ifdef MUX_SCAN_PARITY_EN
  localparam int LASTCH = 7;
`else
  localparam int LASTCH = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, ack1 = 1'b0, start3 = 1'b0, ack3 = 1'b0;
  logic [7:0] mux1 = 8'h00, mux3 = 8'h00;
  logic       din1, din3;
  logic [2:0] s1, s3;
  logic [6:0] q1, q3;
  logic       valid1, busy1, perr1, valid3, busy3, perr3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign din1 = mux1[s1];
  assign din3 = mux3[s3];

  mux_scan_capture #(.SLOT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .din(din1), .ack(ack1),
    .s(s1), .q(q1), .valid(valid1), .busy(busy1), .par_err(perr1)
  );

  mux_scan_capture #(.SLOT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .din(din3), .ack(ack3),
    .s(s3), .q(q3), .valid(valid3), .busy(busy3), .par_err(perr3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected parity flag for a completed scan of data d with spare input p.
  function automatic logic exp_perr(input logic [6:0] d, input logic p);
`ifdef MUX_SCAN_PARITY_EN
    return (^d) ^ p;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    int n;
    // Reset then idle
    rst_n = 1'b0;
    tick(); tick();
    check("reset1", {29'd0, s1, q1, valid1, busy1, perr1}, 32'd0);
    check("reset3", {29'd0, s3, q3, valid3, busy3, perr3}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle1", {29'd0, s1, q1, valid1, busy1, perr1}, 32'd0);
    end

    // Basic scan: i0..i6 = 0,1,0,1,0,1,0 -> 7'h2A; spare input 1
    mux1 = 8'hAA;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("basic_busy0", busy1, 1);
    check("basic_s0", s1, 0);
    for (int i = 1; i <= LASTCH; i++) begin
      tick();
      check("basic_s", s1, i);
      check("basic_valid_lo", valid1, 0);
    end
    tick();
    check("basic_valid", valid1, 1);
    check("basic_q", q1, 7'h2A);
    check("basic_busy_lo", busy1, 0);
    check("basic_s_back", s1, 0);
    check("basic_perr", perr1, exp_perr(7'h2A, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("basic_hold", {valid1, q1}, {1'b1, 7'h2A});
    end
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("basic_ack_valid", valid1, 0);
    check("basic_ack_q", q1, 7'h2A);
    check("basic_ack_perr", perr1, 0);

    // Slow scan: inputs 1,1,1,0,0,0,1 -> 7'h47; each s held 3 clocks
    mux3 = 8'h47;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (n = 0; n < 3 * (LASTCH + 1) - 1; n++) begin
      check("slow_s", s3, n / 3);
      check("slow_busy", busy3, 1);
      tick();
    end
    // n clocks after the start edge; valid needs one more
    tick();
    n++;
    check("slow_latency", n, 3 * (LASTCH + 1));
    check("slow_valid", valid3, 1);
    check("slow_q", q3, 7'h47);
    check("slow_perr", perr3, exp_perr(7'h47, 1'b0));
    ack3 = 1'b1;
    tick();
    ack3 = 1'b0;
    check("slow_ack", valid3, 0);

    // Abort at s=4 during a scan of 7'h7F
    mux1 = 8'h7F;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_s4", s1, 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_reset", {29'd0, s1, q1, valid1, busy1, perr1}, 32'd0);
    mux1 = 8'h15;
    start1 = 1'b1;
    tick();
    n = 0;
    // Start is pulsed again mid-scan; it must not queue another scan.
    while (!valid1 && n < 40) begin
      start1 = (n == 3);
      tick();
      n++;
    end
    start1 = 1'b0;
    check("abort_latency", n, LASTCH + 1);
    check("abort_q", q1, 7'h15);
    check("abort_perr", perr1, exp_perr(7'h15, 1'b0));

    // Handshake corners in DONE
    start1 = 1'b1;
    tick();
    check("done_start_ignored", {valid1, busy1}, 2'b10);
    ack1 = 1'b1;
    tick();
    start1 = 1'b0;
    ack1 = 1'b0;
    check("start_ack_idle", {valid1, busy1}, 2'b00);
    check("start_ack_q", q1, 7'h15);
    ack1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_no_scan", {valid1, busy1}, 2'b00);
    end
    ack1 = 1'b0;

    // Start held high: one IDLE cycle between ack and the next scan
    mux1 = 8'h0C;
    start1 = 1'b1;
    n = 0;
    tick();
    while (!valid1 && n < 40) begin
      tick();
      n++;
    end
    check("held_valid", valid1, 1);
    check("held_q", q1, 7'h0C);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("held_idle_gap", {valid1, busy1}, 2'b00);
    tick();
    check("held_restart", busy1, 1);
    start1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
